// File: rtl/control_unit.sv
// rtl/control_unit.sv - Multi-cycle control sequencer for the cs147sec05 32-bit processor
//
// Steps every instruction through FETCH, DECODE, EXE, MEM and WB, one clock
// each, and decodes the state plus the IR into the datapath control word.
//
// Ports:
//   CLK          system clock, all state changes on the rising edge
//   RST          asynchronous active-low reset (forces IDLE, CTRL = 0)
//   INSTRUCTION  IR contents, opcode [31:26], funct [5:0]
//   ZERO         ALU zero flag, used for the beq/bne branch decision in WB
//   CTRL         datapath control word (bits [31:29] always 0)
//   READ         memory read strobe, mirrors CTRL[5]
//   WRITE        memory write strobe, mirrors CTRL[6]
//
// Configuration: define CU_STACK_EN to decode push (0x1b) and pop (0x1c);
// otherwise they are treated as undefined opcodes.
module control_unit #(
  parameter int CTRL_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           INSTRUCTION,
  input  logic                  ZERO,
  output logic [CTRL_WIDTH-1:0] CTRL,
  output logic                  READ,
  output logic                  WRITE
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXE    = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam int PC_LOAD   = 0;
  localparam int PC_SEL_1  = 1;
  localparam int PC_SEL_2  = 2;
  localparam int PC_SEL_3  = 3;
  localparam int IR_LOAD   = 4;
  localparam int MEM_R     = 5;
  localparam int MEM_W     = 6;
  localparam int R1_SEL_1  = 7;
  localparam int REG_R     = 8;
  localparam int REG_W     = 9;
  localparam int WA_SEL_1  = 10;
  localparam int WA_SEL_2  = 11;
  localparam int WA_SEL_3  = 12;
  localparam int WD_SEL_1  = 13;
  localparam int WD_SEL_2  = 14;
  localparam int WD_SEL_3  = 15;
  localparam int SP_LOAD   = 16;
  localparam int OP1_SEL_1 = 17;
  localparam int OP2_SEL_1 = 18;
  localparam int OP2_SEL_2 = 19;
  localparam int OP2_SEL_3 = 20;
  localparam int OP2_SEL_4 = 21;
  localparam int ALU_LSB   = 22;
  localparam int MA_SEL_1  = 26;
  localparam int MA_SEL_2  = 27;
  localparam int MD_SEL_1  = 28;

  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_MUL = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_AND = 4'd6;
  localparam logic [3:0] ALU_OR  = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9;

  logic [2:0]            state;
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic                  unused_fields;
  logic                  r_alu, r_shift, r_jr;
  logic                  i_alu_se, i_alu_ze, is_lui, is_beq, is_bne;
  logic                  is_lw, is_sw, is_jmp, is_jal, is_push, is_pop;
  logic [3:0]            alu_code;
  logic                  defined, writes_rd, writes_rt, writes_reg;
  logic [CTRL_WIDTH-1:0] held;
  logic [CTRL_WIDTH-1:0] ctrl;

  assign opcode        = INSTRUCTION[31:26];
  assign funct         = INSTRUCTION[5:0];
  assign unused_fields = ^INSTRUCTION[25:6];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= S_EXE;
        S_EXE:    state <= S_MEM;
        S_MEM:    state <= S_WB;
        S_WB:     state <= S_FETCH;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Instruction classification; anything not matched leaves every flag low.
  always_comb begin
    r_alu    = 1'b0;
    r_shift  = 1'b0;
    r_jr     = 1'b0;
    i_alu_se = 1'b0;
    i_alu_ze = 1'b0;
    is_lui   = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_jmp   = 1'b0;
    is_jal   = 1'b0;
    is_push  = 1'b0;
    is_pop   = 1'b0;
    alu_code = 4'd0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin r_alu = 1'b1;   alu_code = ALU_ADD; end
          6'h22: begin r_alu = 1'b1;   alu_code = ALU_SUB; end
          6'h2c: begin r_alu = 1'b1;   alu_code = ALU_MUL; end
          6'h24: begin r_alu = 1'b1;   alu_code = ALU_AND; end
          6'h25: begin r_alu = 1'b1;   alu_code = ALU_OR;  end
          6'h27: begin r_alu = 1'b1;   alu_code = ALU_NOR; end
          6'h2a: begin r_alu = 1'b1;   alu_code = ALU_SLT; end
          6'h01: begin r_shift = 1'b1; alu_code = ALU_SHL; end
          6'h02: begin r_shift = 1'b1; alu_code = ALU_SHR; end
          6'h08: r_jr = 1'b1;
          default: ;
        endcase
      end
      6'h08: begin i_alu_se = 1'b1; alu_code = ALU_ADD; end
      6'h0a: begin i_alu_se = 1'b1; alu_code = ALU_SLT; end
      6'h0c: begin i_alu_ze = 1'b1; alu_code = ALU_AND; end
      6'h0d: begin i_alu_ze = 1'b1; alu_code = ALU_OR;  end
      6'h0f: is_lui = 1'b1;
      6'h04: begin is_beq = 1'b1; alu_code = ALU_SUB; end
      6'h05: begin is_bne = 1'b1; alu_code = ALU_SUB; end
      6'h23: begin is_lw = 1'b1;  alu_code = ALU_ADD; end
      6'h2b: begin is_sw = 1'b1;  alu_code = ALU_ADD; end
      6'h02: is_jmp = 1'b1;
      6'h03: is_jal = 1'b1;
`ifdef CU_STACK_EN
      6'h1b: begin is_push = 1'b1; alu_code = ALU_SUB; end
      6'h1c: begin is_pop = 1'b1;  alu_code = ALU_ADD; end
`else
      6'h1b, 6'h1c: ;
`endif
      default: ;
    endcase
  end

  assign writes_rd  = r_alu | r_shift;
  assign writes_rt  = i_alu_se | i_alu_ze | is_lui | is_lw;
  assign writes_reg = writes_rd | writes_rt | is_jal | is_pop;
  assign defined    = writes_rd | r_jr | i_alu_se | i_alu_ze | is_lui | is_beq | is_bne
                    | is_lw | is_sw | is_jmp | is_jal | is_push | is_pop;

  // Register read and ALU operand selects, held from EXE through WB so that
  // ALU_out and ZERO stay stable while memory and the write-back use them.
  always_comb begin
    held                  = '0;
    held[REG_R]           = defined;
    held[R1_SEL_1]        = is_push;
    held[ALU_LSB +: 4]    = alu_code;
    held[OP2_SEL_4]       = r_alu | is_beq | is_bne;
    held[OP2_SEL_3]       = r_shift | is_push | is_pop;
    held[OP2_SEL_1]       = r_shift;
    held[OP2_SEL_2]       = i_alu_se | is_lw | is_sw;
    held[OP1_SEL_1]       = is_push | is_pop;
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl[MEM_R]    = 1'b1;
        ctrl[MA_SEL_2] = 1'b1;
        ctrl[IR_LOAD]  = 1'b1;
      end
      S_DECODE: begin
        ctrl[REG_R]    = defined;
        ctrl[R1_SEL_1] = is_push;
      end
      S_EXE: ctrl = held;
      S_MEM: begin
        ctrl           = held;
        ctrl[MEM_R]    = is_lw | is_pop;
        ctrl[MEM_W]    = is_sw | is_push;
        ctrl[MA_SEL_1] = is_push;
        ctrl[MD_SEL_1] = is_push;
      end
      S_WB: begin
        ctrl           = held;
        ctrl[PC_LOAD]  = 1'b1;
        ctrl[PC_SEL_1] = !r_jr;
        ctrl[PC_SEL_3] = !(is_jmp | is_jal);
        ctrl[PC_SEL_2] = (is_beq & ZERO) | (is_bne & !ZERO);
        ctrl[REG_W]    = writes_reg;
        // rd/rt go through wa_sel_3=1; R31 (jal) and R0 (pop) through wa_sel_3=0.
        ctrl[WA_SEL_3] = writes_rd | writes_rt;
        ctrl[WA_SEL_1] = writes_rt;
        ctrl[WA_SEL_2] = is_jal;
        // wd_sel_3=0 picks PC+1 for jal; otherwise ALU, immediate or memory data.
        ctrl[WD_SEL_3] = writes_reg & !is_jal;
        ctrl[WD_SEL_2] = is_lui;
        ctrl[WD_SEL_1] = is_lw | is_pop;
        ctrl[SP_LOAD]  = is_push | is_pop;
      end
      default: ctrl = '0;
    endcase
  end

  assign CTRL  = ctrl;
  assign READ  = ctrl[MEM_R];
  assign WRITE = ctrl[MEM_W];

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - Self-checking bench for control_unit
module tb_control_unit;

  logic        CLK;
  logic        RST;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic [31:0] CTRL;
  logic        READ;
  logic        WRITE;

  int errors = 0;
  int checks = 0;

  control_unit #(.CTRL_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
    .CTRL(CTRL), .READ(READ), .WRITE(WRITE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [2:0] OP_NONE = 3'd0, OP_REG = 3'd1, OP_SHAMT = 3'd2;
  localparam logic [2:0] OP_SIMM = 3'd3, OP_ZIMM = 3'd4, OP_ONE = 3'd5;
  localparam logic [1:0] D_RD = 2'd0, D_RT = 2'd1, D_R31 = 2'd2, D_R0 = 2'd3;
  localparam logic [1:0] W_ALU = 2'd0, W_MEM = 2'd1, W_IMM = 2'd2, W_PC = 2'd3;
  localparam logic [1:0] M_NONE = 2'd0, M_RD = 2'd1, M_WR = 2'd2, M_PUSH = 2'd3;
  localparam logic [2:0] P_NEXT = 3'd0, P_BEQ = 3'd1, P_BNE = 3'd2, P_JR = 3'd3, P_JUMP = 3'd4;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu;
    logic [2:0] op2;
    logic       wr;
    logic [1:0] dst;
    logic [1:0] wd;
    logic [1:0] mem;
    logic [2:0] pc;
    logic       sp;
  } attr_t;

  function automatic attr_t mk(input logic [3:0] alu, input logic [2:0] op2, input logic wr,
                               input logic [1:0] dst, input logic [1:0] wd, input logic [1:0] mem,
                               input logic [2:0] pc, input logic sp);
    attr_t a;
    a.valid = 1'b1; a.alu = alu; a.op2 = op2; a.wr = wr; a.dst = dst;
    a.wd = wd; a.mem = mem; a.pc = pc; a.sp = sp;
    return a;
  endfunction

  // Instruction set table: what each instruction does, in datapath terms.
  function automatic attr_t describe(input logic [31:0] ins);
    attr_t a;
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    a = '0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: a = mk(4'd1, OP_REG,   1, D_RD, W_ALU, M_NONE, P_NEXT, 0);
        6'h22: a = mk(4'd2, OP_REG,   1, D_RD, W_ALU, M_NONE, P_NEXT, 0);
        6'h2c: a = mk(4'd3, OP_REG,   1, D_RD, W_ALU, M_NONE, P_NEXT, 0);
        6'h24: a = mk(4'd6, OP_REG,   1, D_RD, W_ALU, M_NONE, P_NEXT, 0);
        6'h25: a = mk(4'd7, OP_REG,   1, D_RD, W_ALU, M_NONE, P_NEXT, 0);
        6'h27: a = mk(4'd8, OP_REG,   1, D_RD, W_ALU, M_NONE, P_NEXT, 0);
        6'h2a: a = mk(4'd9, OP_REG,   1, D_RD, W_ALU, M_NONE, P_NEXT, 0);
        6'h01: a = mk(4'd5, OP_SHAMT, 1, D_RD, W_ALU, M_NONE, P_NEXT, 0);
        6'h02: a = mk(4'd4, OP_SHAMT, 1, D_RD, W_ALU, M_NONE, P_NEXT, 0);
        6'h08: a = mk(4'd0, OP_NONE,  0, D_RD, W_ALU, M_NONE, P_JR,   0);
        default: a = '0;
      endcase
    end else begin
      case (op)
        6'h08: a = mk(4'd1, OP_SIMM, 1, D_RT,  W_ALU, M_NONE, P_NEXT, 0);
        6'h0a: a = mk(4'd9, OP_SIMM, 1, D_RT,  W_ALU, M_NONE, P_NEXT, 0);
        6'h0c: a = mk(4'd6, OP_ZIMM, 1, D_RT,  W_ALU, M_NONE, P_NEXT, 0);
        6'h0d: a = mk(4'd7, OP_ZIMM, 1, D_RT,  W_ALU, M_NONE, P_NEXT, 0);
        6'h0f: a = mk(4'd0, OP_NONE, 1, D_RT,  W_IMM, M_NONE, P_NEXT, 0);
        6'h04: a = mk(4'd2, OP_REG,  0, D_RD,  W_ALU, M_NONE, P_BEQ,  0);
        6'h05: a = mk(4'd2, OP_REG,  0, D_RD,  W_ALU, M_NONE, P_BNE,  0);
        6'h23: a = mk(4'd1, OP_SIMM, 1, D_RT,  W_MEM, M_RD,   P_NEXT, 0);
        6'h2b: a = mk(4'd1, OP_SIMM, 0, D_RD,  W_ALU, M_WR,   P_NEXT, 0);
        6'h02: a = mk(4'd0, OP_NONE, 0, D_RD,  W_ALU, M_NONE, P_JUMP, 0);
        6'h03: a = mk(4'd0, OP_NONE, 1, D_R31, W_PC,  M_NONE, P_JUMP, 0);
`ifdef CU_STACK_EN
        6'h1b: a = mk(4'd2, OP_ONE,  0, D_RD,  W_ALU, M_PUSH, P_NEXT, 1);
        6'h1c: a = mk(4'd1, OP_ONE,  1, D_R0,  W_MEM, M_RD,   P_NEXT, 1);
`endif
        default: a = '0;
      endcase
    end
    return a;
  endfunction

  // Expected control word for stage stg (0 IDLE, 1 FETCH .. 5 WB).
  function automatic logic [31:0] expect_ctrl(input int stg, input logic [31:0] ins, input logic z);
    attr_t a;
    logic [31:0] hold;
    logic [31:0] c;
    a = describe(ins);
    hold = '0;
    if (a.valid) begin
      hold[8] = 1'b1;
      hold[7] = (a.mem == M_PUSH);
      hold[25:22] = a.alu;
      hold[17] = a.sp;
      case (a.op2)
        OP_REG:   hold[21] = 1'b1;
        OP_SHAMT: begin hold[20] = 1'b1; hold[18] = 1'b1; end
        OP_SIMM:  hold[19] = 1'b1;
        OP_ONE:   hold[20] = 1'b1;
        default:  ;
      endcase
    end
    c = '0;
    case (stg)
      1: c = 32'h0800_0030;
      2: c = hold & 32'h0000_0180;
      3: c = hold;
      4: begin
        c = hold;
        if (a.mem == M_RD) c[5] = 1'b1;
        if (a.mem == M_WR) c[6] = 1'b1;
        if (a.mem == M_PUSH) begin c[6] = 1'b1; c[26] = 1'b1; c[28] = 1'b1; end
      end
      5: begin
        c = hold;
        c[0] = 1'b1;
        c[1] = (a.pc != P_JR);
        c[3] = (a.pc != P_JUMP);
        c[2] = (a.pc == P_BEQ) ? z : ((a.pc == P_BNE) ? !z : 1'b0);
        if (a.wr) begin
          c[9] = 1'b1;
          case (a.dst)
            D_RD:  c[12] = 1'b1;
            D_RT:  begin c[12] = 1'b1; c[10] = 1'b1; end
            D_R31: c[11] = 1'b1;
            default: ;
          endcase
          case (a.wd)
            W_ALU: c[15] = 1'b1;
            W_MEM: begin c[15] = 1'b1; c[13] = 1'b1; end
            W_IMM: begin c[15] = 1'b1; c[14] = 1'b1; end
            default: ;
          endcase
        end
        c[16] = a.sp;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_stage(input int stg, input string name);
    logic [31:0] e;
    e = expect_ctrl(stg, INSTRUCTION, ZERO);
    chk($sformatf("%s s%0d ctrl", name, stg), CTRL, e);
    chk($sformatf("%s s%0d read", name, stg), {31'b0, READ}, {31'b0, e[5]});
    chk($sformatf("%s s%0d write", name, stg), {31'b0, WRITE}, {31'b0, e[6]});
  endtask

  // Walk one instruction from FETCH up to stage last (5 = full WB).
  task automatic run_instr(input logic [31:0] ins, input logic zwb, input int last, input string name);
    for (int s = 1; s <= last; s++) begin
      @(negedge CLK);
      if (s == 1) INSTRUCTION = ins;
      ZERO = (s == 5) ? zwb : 1'($urandom_range(0, 1));
      #1;
      check_stage(s, name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [5:0]  op_tab [16];
  logic [5:0]  fn_tab [11];
  logic [5:0]  op_pick;
  logic [5:0]  fn_pick;
  logic [31:0] rnd;
  logic [31:0] ins;

  initial begin
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
               6'h0a, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h1b, 6'h1c};
    fn_tab = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h01, 6'h02, 6'h08, 6'h3f};

    RST = 1'b0;
    INSTRUCTION = 32'h0;
    ZERO = 1'b0;

    repeat (3) begin
      @(posedge CLK);
      #1;
      chk("reset ctrl", CTRL, 32'h0);
      chk("reset read", {31'b0, READ}, 32'h0);
      chk("reset write", {31'b0, WRITE}, 32'h0);
    end
    @(negedge CLK);
    RST = 1'b1;

    // add: explicit EXE and WB field checks on top of the model comparison
    run_instr({6'h00, 20'h12345, 6'h20}, 1'b0, 3, "add");
    chk("add exe op2_sel_4", {31'b0, CTRL[21]}, 32'h1);
    chk("add exe alu", {28'b0, CTRL[25:22]}, 32'h1);
    for (int s = 4; s <= 5; s++) begin
      @(negedge CLK);
      ZERO = 1'($urandom_range(0, 1));
      #1;
      check_stage(s, "add");
    end
    chk("add wb fields", CTRL & 32'h0000_120B, 32'h0000_120B);

    run_instr({6'h04, 26'h0ABCDEF}, 1'b1, 5, "beq");
    chk("beq zero1 pc_sel_2", {31'b0, CTRL[2]}, 32'h1);
    run_instr({6'h05, 26'h0ABCDEF}, 1'b1, 5, "bne");
    chk("bne zero1 pc_sel_2", {31'b0, CTRL[2]}, 32'h0);

    run_instr({6'h23, 26'h1234567}, 1'b0, 4, "lw");
    chk("lw mem read", {30'b0, READ, WRITE}, 32'h2);
    chk("lw mem ma_sel_2", {31'b0, CTRL[27]}, 32'h0);
    @(negedge CLK);
    #1;
    check_stage(5, "lw");
    chk("lw wb fields", CTRL & 32'h0000_2600, 32'h0000_2600);

    run_instr({6'h03, 26'h0000100}, 1'b0, 5, "jal");
    chk("jal wb fields", CTRL & 32'h0000_9808, 32'h0000_0800);

    run_instr({6'h1b, 26'h0}, 1'b0, 4, "push");
`ifdef CU_STACK_EN
    chk("push mem", {CTRL[28], CTRL[26], WRITE}, 32'h7);
`else
    chk("push mem nostack", {31'b0, WRITE}, 32'h0);
`endif
    @(negedge CLK);
    #1;
    check_stage(5, "push");
`ifdef CU_STACK_EN
    chk("push wb sp_load/alu", {27'b0, CTRL[16], CTRL[25:22]}, 32'h12);
`else
    chk("push wb sp_load nostack", {31'b0, CTRL[16]}, 32'h0);
`endif

    // Reset dropped during MEM of sw must clear WRITE immediately.
    run_instr({6'h2b, 26'h0333333}, 1'b0, 4, "sw");
    chk("sw mem write", {31'b0, WRITE}, 32'h1);
    RST = 1'b0;
    #1;
    chk("abort ctrl", CTRL, 32'h0);
    chk("abort write", {31'b0, WRITE}, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    chk("abort idle ctrl", CTRL, 32'h0);
    RST = 1'b1;
    run_instr({6'h00, 20'h0, 6'h3f}, 1'b0, 5, "undef funct");

    for (int n = 0; n < 80; n++) begin
      rnd = $urandom();
      op_pick = op_tab[$urandom_range(0, 15)];
      fn_pick = fn_tab[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) == 0) op_pick = 6'($urandom());
      if ($urandom_range(0, 7) == 0) fn_pick = 6'($urandom());
      ins = {op_pick, rnd[25:6], fn_pick};
      run_instr(ins, 1'($urandom_range(0, 1)), 5, $sformatf("rand%0d ins=%h", n, ins));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
